// File: rtl/seg7_disp_arbiter_if.sv
// seg7_disp_arbiter_if: request/display bundle between two requesters and the
// seven-segment display arbiter.
//   req_i   : per-requester request, held high until its ack
//   val0_i  : requester 0 value, NDIG hex digits, digit 0 in [3:0]
//   val1_i  : requester 1 value
//   lzb_i   : leading-zero blanking enable, sampled when a value is latched
//   ack_o   : one-cycle pulse, value latched for that requester
//   owner_o : one-hot current display owner, 0 = none since reset
//   digit_o : registered 4-bit codes per digit
//   blank_o : registered per-digit blank, 1 = dark
interface seg7_disp_arbiter_if #(parameter int NDIG = 6);
  logic [1:0]        req_i;
  logic [4*NDIG-1:0] val0_i;
  logic [4*NDIG-1:0] val1_i;
  logic              lzb_i;
  logic [1:0]        ack_o;
  logic [1:0]        owner_o;
  logic [4*NDIG-1:0] digit_o;
  logic [NDIG-1:0]   blank_o;

  modport master (output req_i, val0_i, val1_i, lzb_i,
                  input  ack_o, owner_o, digit_o, blank_o);
  modport slave  (input  req_i, val0_i, val1_i, lzb_i,
                  output ack_o, owner_o, digit_o, blank_o);
endinterface

// File: rtl/seg7_disp_arbiter.sv
// seg7_disp_arbiter: shares one NDIG-digit seven-segment bank between two
// requesters. A granted value is latched and held for at least HOLD clocks,
// then the display is re-arbitrated round-robin.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seg7_disp_arbiter_if (req/val/lzb in,
//           ack/owner/digit/blank out, all outputs registered)
module seg7_disp_arbiter #(
  parameter int NDIG = 6,
  parameter int HOLD = 50000000,
  parameter int CW   = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_disp_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_OPEN} state_t;

  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ptr_q, ptr_d;      // requester favoured on a tie
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        owner_q, owner_d;
  logic [4*NDIG-1:0] digit_q, digit_d;
  logic [NDIG-1:0]   blank_q, blank_d;

  logic              win;
  logic [4*NDIG-1:0] win_val;
  logic [NDIG-1:0]   lz_blank;
  logic              hold_done, arb_pt, grant;

  // Winner: a lone request wins outright, a tie goes to the pointer.
  assign win     = (bus.req_i == 2'b10) || ((bus.req_i == 2'b11) && ptr_q);
  assign win_val = win ? bus.val1_i : bus.val0_i;

  // Digit i goes dark when it and every digit above it are zero; digit 0
  // always stays lit so a zero value shows a single "0".
  assign lz_blank[0] = 1'b0;
  for (genvar i = 1; i < NDIG; i++) begin : g_lzb
    assign lz_blank[i] = bus.lzb_i & ~(|win_val[4*NDIG-1:4*i]);
  end

  assign hold_done = (state_q == S_SHOW) && (cnt_q == HOLD_M1);
  assign arb_pt    = (state_q != S_SHOW) || hold_done;
  assign grant     = arb_pt && (|bus.req_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ack_d   = 2'b00;
    owner_d = owner_q;
    digit_d = digit_q;
    blank_d = blank_q;
    if (grant) begin
      digit_d = win_val;
      blank_d = lz_blank;
      ack_d   = win ? 2'b10 : 2'b01;
      owner_d = win ? 2'b10 : 2'b01;
      ptr_d   = ~win;
      cnt_d   = '0;
      state_d = S_SHOW;
    end else if (hold_done) begin
      state_d = S_OPEN;                 // counter freezes, display kept
    end else if (state_q == S_SHOW) begin
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      ack_q   <= 2'b00;
      owner_q <= 2'b00;
      digit_q <= '0;
      blank_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.owner_o = owner_q;
  assign bus.digit_o = digit_q;
  assign bus.blank_o = blank_q;

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Directed bench for seg7_disp_arbiter with HOLD=4, NDIG=6.
module tb_seg7_disp_arbiter;
  localparam int NDIG = 6;
  localparam int HOLD = 4;
  localparam int CW   = 26;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  seg7_disp_arbiter_if #(.NDIG(NDIG)) bus ();

  seg7_disp_arbiter #(.NDIG(NDIG), .HOLD(HOLD), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req_i  = 2'b00;
    bus.val0_i = '0;
    bus.val1_i = '0;
    bus.lzb_i  = 1'b0;

    // reset values
    #12;
    chk("rst_ack",   32'(bus.ack_o),   32'h0);
    chk("rst_owner", 32'(bus.owner_o), 32'h0);
    chk("rst_digit", 32'(bus.digit_o), 32'h0);
    chk("rst_blank", 32'(bus.blank_o), 32'h3F);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    chk("idle_blank", 32'(bus.blank_o), 32'h3F);
    chk("idle_ack",   32'(bus.ack_o),   32'h0);

    // single request from IDLE, leading-zero blanking on
    bus.req_i = 2'b01; bus.val0_i = 24'h00A3F0; bus.lzb_i = 1'b1;
    tick();
    chk("g0_ack",   32'(bus.ack_o),   32'h1);
    chk("g0_digit", 32'(bus.digit_o), 32'h00A3F0);
    chk("g0_blank", 32'(bus.blank_o), 32'h30);
    chk("g0_owner", 32'(bus.owner_o), 32'h1);
    bus.req_i = 2'b00;
    tick();
    chk("g0_pulse", 32'(bus.ack_o), 32'h0);

    // requester 1 arrives mid-hold, value zero with blanking
    bus.req_i = 2'b10; bus.val1_i = 24'h000000; bus.lzb_i = 1'b1;
    tick(); chk("wait1", 32'(bus.ack_o), 32'h0);
    tick(); chk("wait2", 32'(bus.ack_o), 32'h0);
    tick();
    chk("g1_ack",   32'(bus.ack_o),   32'h2);
    chk("g1_owner", 32'(bus.owner_o), 32'h2);
    chk("g1_digit", 32'(bus.digit_o), 32'h0);
    chk("g1_blank", 32'(bus.blank_o), 32'h3E);
    bus.req_i = 2'b00;

    // hold expires, 20 idle cycles in OPEN, display unchanged
    repeat (HOLD + 20) tick();
    chk("open_ack",   32'(bus.ack_o),   32'h0);
    chk("open_owner", 32'(bus.owner_o), 32'h2);
    chk("open_digit", 32'(bus.digit_o), 32'h0);
    chk("open_blank", 32'(bus.blank_o), 32'h3E);
    bus.req_i = 2'b01; bus.val0_i = 24'h001234; bus.lzb_i = 1'b0;
    tick();
    chk("open_gack",   32'(bus.ack_o),   32'h1);
    chk("open_gdigit", 32'(bus.digit_o), 32'h001234);
    chk("open_gblank", 32'(bus.blank_o), 32'h0);
    bus.req_i = 2'b00;
    tick();

    // reset so the pointer favours requester 0, then continuous dual requests
    rst_n = 1'b0;
    #1;
    chk("rst2_owner", 32'(bus.owner_o), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.req_i = 2'b11; bus.val0_i = 24'h111111; bus.val1_i = 24'h222222; bus.lzb_i = 1'b0;
    tick();
    chk("alt0_ack",   32'(bus.ack_o),   32'h1);
    chk("alt0_digit", 32'(bus.digit_o), 32'h111111);
    for (int i = 0; i < HOLD - 1; i++) begin
      tick(); chk("alt0_gap", 32'(bus.ack_o), 32'h0);
    end
    tick();
    chk("alt1_ack",   32'(bus.ack_o),   32'h2);
    chk("alt1_digit", 32'(bus.digit_o), 32'h222222);
    chk("alt1_owner", 32'(bus.owner_o), 32'h2);
    for (int i = 0; i < HOLD - 1; i++) begin
      tick(); chk("alt1_gap", 32'(bus.ack_o), 32'h0);
    end
    tick();
    chk("alt2_ack",   32'(bus.ack_o),   32'h1);
    chk("alt2_owner", 32'(bus.owner_o), 32'h1);

    // reset two cycles into a hold: outputs clear without a clock edge
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_blank", 32'(bus.blank_o), 32'h3F);
    chk("mrst_owner", 32'(bus.owner_o), 32'h0);
    chk("mrst_ack",   32'(bus.ack_o),   32'h0);
    chk("mrst_digit", 32'(bus.digit_o), 32'h0);
    bus.req_i = 2'b10;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    tick();
    chk("post_ack",   32'(bus.ack_o),   32'h2);
    chk("post_owner", 32'(bus.owner_o), 32'h2);
    chk("post_digit", 32'(bus.digit_o), 32'h222222);
    bus.req_i = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
